// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared defaults, FSM states and saturating add for the PE reducer
package pe_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 24;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  // Sum formed in 64 bits; when sat is clear the caller's truncation to acc_w bits wraps.
  function automatic logic signed [63:0] sat_add(
    input  logic signed [63:0] a,
    input  logic signed [63:0] b,
    input  int                 acc_w,
    input  logic               sat,
    output logic               hit
  );
    logic signed [63:0] s, hi, lo;
    s   = a + b;
    hi  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    hit = 1'b0;
    if (sat && (s > hi)) begin
      hit = 1'b1;
      s   = hi;
    end else if (sat && (s < lo)) begin
      hit = 1'b1;
      s   = lo;
    end
    return s;
  endfunction
endpackage

// File: rtl/pe_run_merge.sv
// rtl/pe_run_merge.sv - compacts enabled lanes of one beat and sums runs of equal coords
module pe_run_merge #(
  parameter int LANES  = 3,
  parameter int A_W    = 21,
  parameter int PROD_W = 32,
  parameter int RUN_W  = 34
) (
  input  logic [LANES-1:0]        en,
  input  logic [LANES*A_W-1:0]    addr,
  input  logic [LANES*PROD_W-1:0] prod,
  input  logic                    prev_valid,
  input  logic [A_W-1:0]          prev_addr,
  output logic [LANES*RUN_W-1:0]  sums,
  output logic [3:0]              run_cnt,
  output logic                    cont,
  output logic [A_W-1:0]          last_addr,
  output logic                    any_en
);
  logic           have;
  int             cur;
  logic [A_W-1:0] cur_addr;

  always_comb begin
    sums     = '0;
    cont     = 1'b0;
    have     = prev_valid;
    cur_addr = prev_addr;
    cur      = -1;
    for (int i = 0; i < LANES; i++) begin
      if (en[i]) begin
        // Slot 0 continues the previous beat's entry when no new run has started yet
        if (!(have && (addr[i*A_W +: A_W] == cur_addr))) begin
          cur = cur + 1;
        end else if (cur < 0) begin
          cur  = 0;
          cont = 1'b1;
        end
        for (int k = 0; k < LANES; k++) begin
          if (k == cur) begin
            sums[k*RUN_W +: RUN_W] = sums[k*RUN_W +: RUN_W]
                                   + RUN_W'($signed(prod[i*PROD_W +: PROD_W]));
          end
        end
        have     = 1'b1;
        cur_addr = addr[i*A_W +: A_W];
      end
    end
    run_cnt   = 4'(cur + 1);
    last_addr = cur_addr;
    any_en    = |en;
  end
endmodule

// File: rtl/pe_reducer_nlane.sv
// rtl/pe_reducer_nlane.sv - multi-lane sparse MAC reducer with run merge and local accumulation buffer
module pe_reducer_nlane
  import pe_pkg::*;
#(
  parameter int LANES     = 3,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int CRD_W     = 7,
  parameter int CRD_N     = 3,
  parameter int BUF_DEPTH = 48,
  parameter int SATURATE  = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [LANES-1:0]              i_lane_en,
  input  logic [LANES*CRD_N*CRD_W-1:0]  i_addr,
  input  logic [LANES*DATA_W-1:0]       i_w,
  input  logic [LANES*DATA_W-1:0]       i_ia,
  input  logic                          i_last,
  input  logic                          i_clear,
  input  logic [$clog2(BUF_DEPTH)-1:0]  i_rd_addr,
  output logic [ACC_W-1:0]              o_rd_data,
  output logic [$clog2(BUF_DEPTH):0]    o_count,
  output logic                          o_done,
  output logic                          o_overflow,
  output logic                          o_sat
);
  localparam int A_W    = CRD_N * CRD_W;
  localparam int PROD_W = 2 * DATA_W;
  localparam int RUN_W  = PROD_W + $clog2(LANES);
  localparam int IDX_W  = $clog2(BUF_DEPTH);
  localparam int CNT_W  = IDX_W + 1;
  localparam int TGT_W  = CNT_W + 4;

  state_t                    state, state_n;
  logic                      accept;
  logic                      s1_valid;
  logic [LANES-1:0]          s1_en;
  logic [LANES*A_W-1:0]      s1_addr;
  logic [LANES*PROD_W-1:0]   s1_prod, prod_in;
  logic signed [PROD_W-1:0]  mul_a, mul_b;
  logic                      cont_valid, cont_drop;
  logic [A_W-1:0]            cont_addr;
  logic [CNT_W-1:0]          ptr, ptr_n;
  logic [TGT_W-1:0]          ptr_sum;
  logic signed [ACC_W-1:0]   mem [BUF_DEPTH];

  logic [LANES*RUN_W-1:0]    run_sums;
  logic [3:0]                run_cnt;
  logic                      run_cont, run_any;
  logic [A_W-1:0]            run_last_addr;

  logic [LANES-1:0]          wen, wdrop, whit;
  logic [TGT_W-1:0]          tgt  [LANES];
  logic [IDX_W-1:0]          widx [LANES];
  logic signed [ACC_W-1:0]   wval [LANES];
  logic                      last_drop;

  assign accept  = i_valid & o_ready & ~i_clear;
  assign o_count = ptr;

  always_comb begin
    prod_in = '0;
    mul_a   = '0;
    mul_b   = '0;
    for (int i = 0; i < LANES; i++) begin
      mul_a = PROD_W'($signed(i_w[i*DATA_W +: DATA_W]));
      mul_b = PROD_W'($signed(i_ia[i*DATA_W +: DATA_W]));
      prod_in[i*PROD_W +: PROD_W] = mul_a * mul_b;
    end
  end

  pe_run_merge #(.LANES(LANES), .A_W(A_W), .PROD_W(PROD_W), .RUN_W(RUN_W)) u_merge (
    .en         (s1_en),
    .addr       (s1_addr),
    .prod       (s1_prod),
    .prev_valid (cont_valid),
    .prev_addr  (cont_addr),
    .sums       (run_sums),
    .run_cnt    (run_cnt),
    .cont       (run_cont),
    .last_addr  (run_last_addr),
    .any_en     (run_any)
  );

  // A continuing slot targets the current entry (ptr-1); new runs take ptr, ptr+1, ...
  always_comb begin
    wen       = '0;
    wdrop     = '0;
    whit      = '0;
    last_drop = cont_drop;
    for (int k = 0; k < LANES; k++) begin
      tgt[k]  = '0;
      widx[k] = '0;
      wval[k] = '0;
      if (s1_valid && (k < int'(run_cnt))) begin
        if (run_cont && (k == 0)) begin
          tgt[k]   = TGT_W'(ptr) - TGT_W'(1);
          wdrop[k] = cont_drop;
        end else begin
          tgt[k]   = TGT_W'(ptr) + TGT_W'(k) - TGT_W'(run_cont);
          wdrop[k] = (tgt[k] >= TGT_W'(BUF_DEPTH));
        end
        wen[k]  = ~wdrop[k];
        widx[k] = tgt[k][IDX_W-1:0];
        if (wen[k]) begin
          wval[k] = ACC_W'(sat_add(64'(mem[widx[k]]),
                                   64'($signed(run_sums[k*RUN_W +: RUN_W])),
                                   ACC_W, SATURATE != 0, whit[k]));
        end
        if (k == int'(run_cnt) - 1) last_drop = wdrop[k];
      end
    end
    ptr_sum = TGT_W'(ptr) + TGT_W'(run_cnt) - TGT_W'(run_cont);
    ptr_n   = (ptr_sum > TGT_W'(BUF_DEPTH)) ? CNT_W'(BUF_DEPTH) : ptr_sum[CNT_W-1:0];
  end

  always_comb begin
    state_n = state;
    o_ready = (state == S_IDLE) || (state == S_RUN);
    o_done  = (state == S_DONE);
    case (state)
      S_IDLE:  if (accept) state_n = i_last ? S_FLUSH : S_RUN;
      S_RUN:   if (accept && i_last) state_n = S_FLUSH;
      S_FLUSH: if (!s1_valid) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (i_clear) state_n = S_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      s1_valid   <= 1'b0;
      s1_en      <= '0;
      s1_addr    <= '0;
      s1_prod    <= '0;
      cont_valid <= 1'b0;
      cont_drop  <= 1'b0;
      cont_addr  <= '0;
      ptr        <= '0;
      o_overflow <= 1'b0;
      o_sat      <= 1'b0;
      o_rd_data  <= '0;
      for (int k = 0; k < BUF_DEPTH; k++) mem[k] <= '0;
    end else begin
      state     <= state_n;
      o_rd_data <= ({1'b0, i_rd_addr} < CNT_W'(BUF_DEPTH)) ? mem[i_rd_addr] : '0;
      if (i_clear) begin
        s1_valid   <= 1'b0;
        cont_valid <= 1'b0;
        cont_drop  <= 1'b0;
        ptr        <= '0;
        o_overflow <= 1'b0;
        o_sat      <= 1'b0;
        for (int k = 0; k < BUF_DEPTH; k++) mem[k] <= '0;
      end else begin
        s1_valid <= accept;
        if (accept) begin
          s1_en   <= i_lane_en;
          s1_addr <= i_addr;
          s1_prod <= prod_in;
        end
        for (int k = 0; k < LANES; k++) begin
          if (wen[k]) mem[widx[k]] <= wval[k];
        end
        if (s1_valid) begin
          ptr <= ptr_n;
          if (|wdrop) o_overflow <= 1'b1;
          if (|whit)  o_sat      <= 1'b1;
          if (run_any) begin
            cont_valid <= 1'b1;
            cont_addr  <= run_last_addr;
            cont_drop  <= last_drop;
          end
        end
        if ((state == S_FLUSH) && !s1_valid) begin
          ptr        <= '0;
          cont_valid <= 1'b0;
          cont_drop  <= 1'b0;
        end
      end
    end
  end
endmodule
